lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Parametrised load/store unit that replaces the inline MEM/WRITEBACK memory sequencing of the multicycle core.
- Accepts one load or store per request from the core over a valid/ready handshake and drives the shared memory bus.
- Aligns byte lanes for a bus DATA_WIDTH of 32 or 64 bits, and performs sign/zero extension of load data.
- Returns a completion response with an error code, and adds a bus timeout watchdog.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; legal values 32 or 64; BYTES = DATA_WIDTH/8; OFS = log2(BYTES).
- MIN_WAIT, 1, cycles after a dispatch pulse during which bus_busy is ignored; legal range 1..15.
- TIMEOUT, 255, maximum wait cycles per beat before the unit aborts with an error; 0 disables the watchdog.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_func  in  3  RV32 funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_dst  in  5  load destination register.
- bus_addr  out  32  bus address, aligned down to BYTES.
- bus_dispatch_read  out  1  one-cycle read pulse.
- bus_dispatch_write  out  1  one-cycle write pulse.
- bus_byte_en  out  BYTES  active byte lanes.
- bus_write_data  out  DATA_WIDTH  lane-shifted store data.
- bus_busy  in  1  bus busy.
- bus_read_data  in  DATA_WIDTH  read data; valid in the first cycle busy is low after the wait window.
- resp_valid  out  1  response valid; held until resp_ready is high.
- resp_ready  in  1  core accepts the response.
- resp_we  out  1  register write enable; 1 only for a successful load with dst != 0.
- resp_dst  out  5  destination register.
- resp_data  out  32  extended load data; 0 for stores.
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal func.

Behaviour:
- Clock and reset: single clock clk_in; rst_in is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; every other output 0.
- Reset mid-operation: the state machine returns to IDLE immediately, dispatch outputs drop asynchronously, and the in-flight bus transaction is abandoned with no response.
- States: IDLE, DISPATCH, WAIT, DISPATCH2, WAIT2, RESP.
- IDLE:
  - req_valid && req_ready at cycle 0 latches the request.
  - Next state is DISPATCH, or RESP if the request is illegal or misaligned; such requests never produce bus traffic.
- DISPATCH:
  - Drive bus_addr, bus_byte_en and bus_write_data.
  - Pulse the dispatch_read/write matching req_is_store for exactly one cycle (cycle 1).
  - Clear the wait counter; go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - If counter >= MIN_WAIT and bus_busy=0, the beat is complete: latch bus_read_data; go to DISPATCH2 if a second beat is pending, else RESP.
  - If TIMEOUT != 0 and counter == TIMEOUT with bus still busy, go to RESP with err=10.
- Minimum latency, acceptance to resp_valid: 3 cycles for a single beat with MIN_WAIT=1.
- RESP:
  - resp_valid=1 with stable outputs until resp_ready=1.
  - On the handshake cycle, go to IDLE; req_ready rises the following cycle.
- Lanes:
  - ofs = req_addr[OFS-1:0]; size is 1, 2 or 4 bytes.
  - byte_en = ((1<<size)-1) << ofs, truncated to BYTES.
  - bus_write_data = req_wdata << (8*ofs); the upper bits are don't-care but must be driven as 0.
- Load extract: rd = bus_read_data >> (8*ofs), then:
  - LB: sign-extend rd[7:0].
  - LBU: zero-extend rd[7:0].
  - LH: sign-extend rd[15:0].
  - LHU: zero-extend rd[15:0].
  - LW: rd[31:0].
- Illegal func: store with funct3 not in {000,001,010}, or load with funct3 011/11x, gives err=11.
- x0: a load to dst=0 still completes on the bus and returns resp_data, but resp_we=0.
- Simultaneous req_valid during RESP: ignored (req_ready=0).

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without it: any access not naturally aligned (LH/SH with addr[0]=1; LW/SW with addr[1:0]!=0) gives err=01, with no bus activity.
- With it: misaligned accesses that fit inside one bus word complete in one beat. Accesses crossing a BYTES boundary are issued as two beats:
  - Beat 1 at the aligned address, lanes ofs..BYTES-1.
  - Beat 2 at the aligned address + BYTES, lanes 0..(ofs+size-BYTES-1).
  - Load data is concatenated low-beat-first before extension.
  - A timeout on either beat gives err=10. For a store, beat 1 remains committed.
  - err=01 is never produced.

Test Plan:
- LW at 0x100, DATA_WIDTH=32, bus returns 0xDEADBEEF, busy low -> one read pulse at cycle 1, bus_addr 0x100, byte_en 1111; resp_valid at cycle 3, resp_data 0xDEADBEEF, resp_we=1, err 00.
- LB at 0x103 with read data 0x80xxxxxx, then LBU at the same address -> resp_data 0xFFFFFF80, then 0x00000080.
- SH 0x1234 at 0x106, DATA_WIDTH=64 -> bus_addr 0x100, byte_en 0xC0, bus_write_data 0x1234_0000_0000_0000, resp_we=0.
- LW at 0x102 -> without the macro: err 01, no dispatch pulse. With the macro and a 32-bit bus: two reads at 0x100 and 0x104 returning 0xBBBBxxxx and 0xxxxxAAAA -> resp_data 0xAAAABBBB.
- bus_busy held high, TIMEOUT=8 -> err 10 exactly 8 cycles after the wait starts. Then hold resp_ready=0 for 5 cycles -> outputs stay stable and req_ready stays 0.
- Assert rst_in mid-WAIT -> dispatch outputs and resp_valid go to 0 without waiting for a clock edge; the next request after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Core request/response and shared memory bus signals of the load/store unit.
// The unit connects through the slave modport; the core/bus side uses master.
interface lsu_mem_port_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_is_store;
    logic [2:0]                req_func;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic [4:0]                req_dst;

    logic [31:0]               bus_addr;
    logic                      bus_dispatch_read;
    logic                      bus_dispatch_write;
    logic [DATA_WIDTH/8-1:0]   bus_byte_en;
    logic [DATA_WIDTH-1:0]     bus_write_data;
    logic                      bus_busy;
    logic [DATA_WIDTH-1:0]     bus_read_data;

    logic                      resp_valid;
    logic                      resp_ready;
    logic                      resp_we;
    logic [4:0]                resp_dst;
    logic [31:0]               resp_data;
    logic [1:0]                resp_err;

    modport slave (
        input  req_valid, req_is_store, req_func, req_addr, req_wdata, req_dst,
        input  bus_busy, bus_read_data, resp_ready,
        output req_ready, bus_addr, bus_dispatch_read, bus_dispatch_write,
        output bus_byte_en, bus_write_data,
        output resp_valid, resp_we, resp_dst, resp_data, resp_err
    );

    modport master (
        output req_valid, req_is_store, req_func, req_addr, req_wdata, req_dst,
        output bus_busy, bus_read_data, resp_ready,
        input  req_ready, bus_addr, bus_dispatch_read, bus_dispatch_write,
        input  bus_byte_en, bus_write_data,
        input  resp_valid, resp_we, resp_dst, resp_data, resp_err
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: one request at a time, byte-lane alignment, load extension, bus watchdog.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into one or two bus beats.
module lsu_mem_port #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MIN_WAIT   = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic          clk_in,
    input logic          rst_in,
    lsu_mem_port_if.slave io
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFS   = $clog2(BYTES);
    localparam int unsigned B2    = 2 * BYTES;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CMAX  = (TIMEOUT > 15) ? TIMEOUT : 15;
    localparam int unsigned CW    = $clog2(CMAX + 2);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_WAIT);
    localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, DISPATCH, WAIT, DISPATCH2, WAIT2, RESP} state_t;
    state_t state, state_n;

    logic                  is_store_q;
    logic [2:0]            func_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            dst_q;
    logic [1:0]            err_q;
    logic [CW-1:0]         cnt, cnt_n, cnt_inc;
    logic [DATA_WIDTH-1:0] rdata_lo, rdata_hi;

    logic                  illegal, misaligned, two_beat;
    logic                  beat_ok, tmo_hit, beat_done, beat_tmo;
    logic [OFS-1:0]        ofs;
    logic [B2-1:0]         sz_mask, mask;
    logic [W2-1:0]         wd_wide;
    logic [31:0]           base1, base2, rd, ext;

    always_comb begin
        illegal = 1'b0;
        unique case (io.req_func)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = io.req_is_store;
            default:                illegal = 1'b1;
        endcase
    end

    assign ofs   = addr_q[OFS-1:0];
    assign base1 = {addr_q[31:OFS], {OFS{1'b0}}};
    assign base2 = base1 + 32'(BYTES);

    always_comb begin
        unique case (func_q[1:0])
            2'b00:   sz_mask = B2'(1);
            2'b01:   sz_mask = B2'(3);
            default: sz_mask = B2'(15);
        endcase
    end

    // Lanes and data are built over two bus words; the upper word feeds the second beat.
    assign mask    = sz_mask << ofs;
    assign wd_wide = W2'(wdata_q) << {ofs, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign misaligned = 1'b0;
    assign two_beat   = |mask[B2-1:BYTES];
`else
    assign misaligned = (io.req_func[1:0] == 2'b01 && io.req_addr[0]) ||
                        (io.req_func[1:0] == 2'b10 && io.req_addr[1:0] != 2'b00);
    assign two_beat   = 1'b0;
`endif

    assign rd = 32'({rdata_hi, rdata_lo} >> {ofs, 3'b000});

    always_comb begin
        unique case (func_q)
            3'b000:  ext = {{24{rd[7]}}, rd[7:0]};
            3'b100:  ext = {24'd0, rd[7:0]};
            3'b001:  ext = {{16{rd[15]}}, rd[15:0]};
            3'b101:  ext = {16'd0, rd[15:0]};
            default: ext = rd;
        endcase
    end

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign beat_ok = (cnt_inc >= MIN_C) && !io.bus_busy;
    assign tmo_hit = (TIMEOUT != 0) && (cnt_inc == TMO_C);

    always_comb begin
        state_n               = state;
        cnt_n                 = cnt;
        beat_done             = 1'b0;
        beat_tmo              = 1'b0;
        io.bus_addr           = '0;
        io.bus_dispatch_read  = 1'b0;
        io.bus_dispatch_write = 1'b0;
        io.bus_byte_en        = '0;
        io.bus_write_data     = '0;
        unique case (state)
            IDLE: begin
                if (io.req_valid)
                    state_n = (illegal || misaligned) ? RESP : DISPATCH;
            end
            DISPATCH, WAIT: begin
                io.bus_addr       = base1;
                io.bus_byte_en    = mask[BYTES-1:0];
                io.bus_write_data = wd_wide[DATA_WIDTH-1:0];
                if (state == DISPATCH) begin
                    io.bus_dispatch_read  = !is_store_q;
                    io.bus_dispatch_write = is_store_q;
                    cnt_n   = '0;
                    state_n = WAIT;
                end else begin
                    cnt_n = cnt_inc;
                    if (beat_ok) begin
                        beat_done = 1'b1;
                        state_n   = two_beat ? DISPATCH2 : RESP;
                    end else if (tmo_hit) begin
                        beat_tmo = 1'b1;
                        state_n  = RESP;
                    end
                end
            end
            DISPATCH2, WAIT2: begin
                io.bus_addr       = base2;
                io.bus_byte_en    = mask[B2-1:BYTES];
                io.bus_write_data = wd_wide[W2-1:DATA_WIDTH];
                if (state == DISPATCH2) begin
                    io.bus_dispatch_read  = !is_store_q;
                    io.bus_dispatch_write = is_store_q;
                    cnt_n   = '0;
                    state_n = WAIT2;
                end else begin
                    cnt_n = cnt_inc;
                    if (beat_ok) begin
                        beat_done = 1'b1;
                        state_n   = RESP;
                    end else if (tmo_hit) begin
                        beat_tmo = 1'b1;
                        state_n  = RESP;
                    end
                end
            end
            RESP: begin
                if (io.resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            is_store_q <= 1'b0;
            func_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            err_q      <= '0;
            rdata_lo   <= '0;
            rdata_hi   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && io.req_valid) begin
                is_store_q <= io.req_is_store;
                func_q     <= io.req_func;
                addr_q     <= io.req_addr;
                wdata_q    <= io.req_wdata;
                dst_q      <= io.req_dst;
                err_q      <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
                rdata_lo   <= '0;
                rdata_hi   <= '0;
            end
            if (beat_done) begin
                if (state == WAIT) rdata_lo <= io.bus_read_data;
                else               rdata_hi <= io.bus_read_data;
            end
            if (beat_tmo)
                err_q <= 2'b10;
        end
    end

    assign io.req_ready  = (state == IDLE);
    assign io.resp_valid = (state == RESP);
    assign io.resp_err   = (state == RESP) ? err_q : 2'b00;
    assign io.resp_dst   = (state == RESP) ? dst_q : 5'd0;
    assign io.resp_data  = (state == RESP && !is_store_q && err_q == 2'b00) ? ext : 32'd0;
    assign io.resp_we    = (state == RESP) && !is_store_q && (err_q == 2'b00) && (dst_q != 5'd0);
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit and a 64-bit instance share one stimulus
// path, selected by sel; expected values are hand-computed constants.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid, req_is_store, resp_ready, bus_busy;
    logic [2:0]  req_func;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_dst;
    logic [31:0] mem32 [4];
    logic [63:0] mem64;

    lsu_mem_port_if #(.DATA_WIDTH(32)) m32 ();
    lsu_mem_port_if #(.DATA_WIDTH(64)) m64 ();

    lsu_mem_port #(.DATA_WIDTH(32), .MIN_WAIT(1), .TIMEOUT(8)) dut32 (
        .clk_in(clk), .rst_in(rst), .io(m32.slave));
    lsu_mem_port #(.DATA_WIDTH(64), .MIN_WAIT(1), .TIMEOUT(8)) dut64 (
        .clk_in(clk), .rst_in(rst), .io(m64.slave));

    assign m32.req_valid     = req_valid & ~sel;
    assign m64.req_valid     = req_valid & sel;
    assign m32.resp_ready    = resp_ready & ~sel;
    assign m64.resp_ready    = resp_ready & sel;
    assign m32.req_is_store  = req_is_store;
    assign m64.req_is_store  = req_is_store;
    assign m32.req_func      = req_func;
    assign m64.req_func      = req_func;
    assign m32.req_addr      = req_addr;
    assign m64.req_addr      = req_addr;
    assign m32.req_wdata     = req_wdata;
    assign m64.req_wdata     = req_wdata;
    assign m32.req_dst       = req_dst;
    assign m64.req_dst       = req_dst;
    assign m32.bus_busy      = bus_busy;
    assign m64.bus_busy      = bus_busy;
    assign m32.bus_read_data = mem32[m32.bus_addr[3:2]];
    assign m64.bus_read_data = mem64;

    logic        o_req_ready, o_rd, o_wr, o_rv, o_we;
    logic [31:0] o_addr, o_data;
    logic [7:0]  o_be;
    logic [63:0] o_wd;
    logic [4:0]  o_dst;
    logic [1:0]  o_err;

    always_comb begin
        if (sel) begin
            o_req_ready = m64.req_ready;  o_rd = m64.bus_dispatch_read; o_wr = m64.bus_dispatch_write;
            o_addr = m64.bus_addr;        o_be = m64.bus_byte_en;       o_wd = m64.bus_write_data;
            o_rv = m64.resp_valid;        o_we = m64.resp_we;           o_dst = m64.resp_dst;
            o_data = m64.resp_data;       o_err = m64.resp_err;
        end else begin
            o_req_ready = m32.req_ready;  o_rd = m32.bus_dispatch_read; o_wr = m32.bus_dispatch_write;
            o_addr = m32.bus_addr;        o_be = {4'd0, m32.bus_byte_en};
            o_wd = {32'd0, m32.bus_write_data};
            o_rv = m32.resp_valid;        o_we = m32.resp_we;           o_dst = m32.resp_dst;
            o_data = m32.resp_data;       o_err = m32.resp_err;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rd, n_wr, r_cyc, p1_cyc;
    logic [31:0] p1_addr, p2_addr, r_data;
    logic [7:0]  p1_be, p2_be;
    logic [63:0] p1_wd;
    logic        r_we;
    logic [1:0]  r_err;
    logic [4:0]  r_dst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, trace bus pulses until the response, hold it, then handshake.
    task automatic run(input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] d, input int hold);
        n_rd = 0; n_wr = 0; p1_cyc = 0;
        p1_addr = '0; p2_addr = '0; p1_be = '0; p2_be = '0; p1_wd = '0;
        req_is_store = st; req_func = f; req_addr = a; req_wdata = wd; req_dst = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        r_cyc = 1;
        while (!o_rv && r_cyc < 40) begin
            if (o_rd || o_wr) begin
                if (n_rd + n_wr == 0) begin
                    p1_cyc = r_cyc; p1_addr = o_addr; p1_be = o_be; p1_wd = o_wd;
                end else begin
                    p2_addr = o_addr; p2_be = o_be;
                end
                n_rd += int'(o_rd);
                n_wr += int'(o_wr);
            end
            tick();
            r_cyc++;
        end
        chk("resp_valid", 64'(o_rv), 64'(1));
        r_data = o_data; r_we = o_we; r_err = o_err; r_dst = o_dst;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            tick();
            chk("hold_valid", 64'(o_rv), 64'(1));
            chk("hold_err", 64'(o_err), 64'(r_err));
            chk("hold_data", 64'(o_data), 64'(r_data));
            chk("hold_req_ready", 64'(o_req_ready), 64'(0));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("post_req_ready", 64'(o_req_ready), 64'(1));
        chk("post_resp_valid", 64'(o_rv), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; resp_ready = 1'b0;
        bus_busy = 1'b0; req_func = '0; req_addr = '0; req_wdata = '0; req_dst = '0;
        mem32[0] = 32'hDEADBEEF; mem32[1] = '0; mem32[2] = '0; mem32[3] = '0; mem64 = '0;
        tick();
        chk("rst_req_ready32", 64'(m32.req_ready), 64'(1));
        chk("rst_req_ready64", 64'(m64.req_ready), 64'(1));
        chk("rst_dispatch", 64'({m32.bus_dispatch_read, m32.bus_dispatch_write}), 64'(0));
        chk("rst_bus_addr", 64'(m32.bus_addr), 64'(0));
        chk("rst_resp", 64'({m32.resp_valid, m32.resp_we, m32.resp_err, m32.resp_data}), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // LW 0x100
        run(1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 0);
        chk("lw_reads", 64'(n_rd), 64'(1));
        chk("lw_writes", 64'(n_wr), 64'(0));
        chk("lw_pulse_cyc", 64'(p1_cyc), 64'(1));
        chk("lw_addr", 64'(p1_addr), 64'h100);
        chk("lw_be", 64'(p1_be), 64'hF);
        chk("lw_resp_cyc", 64'(r_cyc), 64'(3));
        chk("lw_data", 64'(r_data), 64'hDEADBEEF);
        chk("lw_we", 64'(r_we), 64'(1));
        chk("lw_err", 64'(r_err), 64'(0));
        chk("lw_dst", 64'(r_dst), 64'(3));

        // LB / LBU / LH / LHU sign handling
        mem32[0] = 32'h80123456;
        run(1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 0);
        chk("lb_data", 64'(r_data), 64'hFFFFFF80);
        chk("lb_be", 64'(p1_be), 64'h8);
        run(1'b0, 3'b100, 32'h103, 32'h0, 5'd5, 0);
        chk("lbu_data", 64'(r_data), 64'h00000080);
        run(1'b0, 3'b001, 32'h102, 32'h0, 5'd6, 0);
        chk("lh_data", 64'(r_data), 64'hFFFF8012);
        run(1'b0, 3'b101, 32'h102, 32'h0, 5'd6, 0);
        chk("lhu_data", 64'(r_data), 64'h00008012);

        // SB 0x101
        run(1'b1, 3'b000, 32'h101, 32'h123456AB, 5'd7, 0);
        chk("sb_writes", 64'(n_wr), 64'(1));
        chk("sb_reads", 64'(n_rd), 64'(0));
        chk("sb_be", 64'(p1_be), 64'h2);
        chk("sb_wdata", p1_wd, 64'h3456AB00);
        chk("sb_resp", 64'({r_we, r_data}), 64'(0));

        // LW 0x102 (misaligned)
        mem32[0] = 32'hBBBB1111;
        mem32[1] = 32'h2222AAAA;
        run(1'b0, 3'b010, 32'h102, 32'h0, 5'd4, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("mis_reads", 64'(n_rd), 64'(2));
        chk("mis_addr1", 64'(p1_addr), 64'h100);
        chk("mis_be1", 64'(p1_be), 64'hC);
        chk("mis_addr2", 64'(p2_addr), 64'h104);
        chk("mis_be2", 64'(p2_be), 64'h3);
        chk("mis_data", 64'(r_data), 64'hAAAABBBB);
        chk("mis_err", 64'(r_err), 64'(0));
        chk("mis_resp_cyc", 64'(r_cyc), 64'(5));
`else
        chk("mis_err", 64'(r_err), 64'(1));
        chk("mis_pulses", 64'(n_rd + n_wr), 64'(0));
        chk("mis_we", 64'(r_we), 64'(0));
        chk("mis_resp_cyc", 64'(r_cyc), 64'(1));
`endif

        // illegal funct3
        run(1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 0);
        chk("ill_store_err", 64'(r_err), 64'(3));
        chk("ill_store_pulses", 64'(n_rd + n_wr), 64'(0));
        chk("ill_store_cyc", 64'(r_cyc), 64'(1));
        run(1'b0, 3'b011, 32'h100, 32'h0, 5'd9, 0);
        chk("ill_load_err", 64'(r_err), 64'(3));
        chk("ill_load_we", 64'(r_we), 64'(0));

        // load to x0
        mem32[0] = 32'hDEADBEEF;
        run(1'b0, 3'b010, 32'h100, 32'h0, 5'd0, 0);
        chk("x0_data", 64'(r_data), 64'hDEADBEEF);
        chk("x0_we", 64'(r_we), 64'(0));
        chk("x0_reads", 64'(n_rd), 64'(1));

        // timeout with a held response
        bus_busy = 1'b1;
        run(1'b0, 3'b010, 32'h100, 32'h0, 5'd2, 5);
        chk("tmo_err", 64'(r_err), 64'(2));
        chk("tmo_resp_cyc", 64'(r_cyc), 64'(10));
        chk("tmo_we", 64'(r_we), 64'(0));
        bus_busy = 1'b0;

        // 64-bit bus
        sel = 1'b1;
        run(1'b1, 3'b001, 32'h106, 32'h00001234, 5'd1, 0);
        chk("sh64_addr", 64'(p1_addr), 64'h100);
        chk("sh64_be", 64'(p1_be), 64'hC0);
        chk("sh64_wdata", p1_wd, 64'h1234_0000_0000_0000);
        chk("sh64_writes", 64'(n_wr), 64'(1));
        chk("sh64_we", 64'(r_we), 64'(0));
        chk("sh64_err", 64'(r_err), 64'(0));
        chk("sh64_resp_cyc", 64'(r_cyc), 64'(3));
        mem64 = 64'hCAFEF00D_11223344;
        run(1'b0, 3'b010, 32'h104, 32'h0, 5'd8, 0);
        chk("lw64_be", 64'(p1_be), 64'hF0);
        chk("lw64_data", 64'(r_data), 64'hCAFEF00D);
        sel = 1'b0;

        // reset in WAIT
        bus_busy = 1'b1;
        req_is_store = 1'b0; req_func = 3'b010; req_addr = 32'h100; req_dst = 5'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_addr", 64'(o_addr), 64'h100);
        rst = 1'b1;
        #1;
        chk("async_rst_addr", 64'(o_addr), 64'(0));
        chk("async_rst_be", 64'(o_be), 64'(0));
        chk("async_rst_valid", 64'(o_rv), 64'(0));
        chk("async_rst_ready", 64'(o_req_ready), 64'(1));
        #2;
        rst = 1'b0;
        tick();

        // reset in DISPATCH
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_pulse", 64'(o_rd), 64'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_pulse", 64'(o_rd), 64'(0));
        #2;
        rst = 1'b0;
        tick();

        // request after reset
        bus_busy = 1'b0;
        mem32[1] = 32'h13579BDF;
        run(1'b0, 3'b010, 32'h104, 32'h0, 5'd11, 0);
        chk("after_rst_data", 64'(r_data), 64'h13579BDF);
        chk("after_rst_cyc", 64'(r_cyc), 64'(3));
        chk("after_rst_reads", 64'(n_rd), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
